tick_period_meter: RTL and testbench
====================================

TICK_PERIOD_METER -- requirements
Module: tick_period_meter

Interface
REQ-001 Parameter CNT_WIDTH, default 16, SHALL set the width of the period count.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2, SHALL set the depth of the tick_in synchronizer.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL be updated on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle request to begin a measurement.
REQ-006 tick_in  input  1  SHALL carry the tick being measured; it is asynchronous to clk.
REQ-007 period  output  CNT_WIDTH  SHALL carry the measured clk cycles between two tick_in rising edges.
REQ-008 valid  output  1  SHALL flag that period holds a completed result.
REQ-009 busy  output  1  SHALL be high while a measurement is in progress.
REQ-010 overflow  output  1  SHALL flag that the last measurement saturated.

Function
REQ-011 tick_in SHALL pass through SYNC_STAGES flops and then a rising-edge detector, giving edge_p, a one-cycle pulse delayed SYNC_STAGES+1 cycles; this fixed delay SHALL cancel out of the result.
REQ-012 The FSM SHALL have states IDLE, ARM, MEASURE and DONE.
REQ-013 IDLE: start=1 SHALL move the FSM to ARM, clear valid and overflow on that edge, and set busy.
REQ-014 ARM: the first edge_p SHALL load the counter with 1 and move the FSM to MEASURE.
REQ-015 MEASURE: the counter SHALL increment by 1 each cycle without edge_p.
REQ-016 MEASURE: on edge_p, period SHALL take the counter value, giving period = N for ticks N clk cycles apart, and the FSM SHALL move to DONE.
REQ-017 MEASURE: if the counter reaches 2^CNT_WIDTH-1 with no edge_p, period SHALL be set to all-ones, overflow set to 1, and the FSM SHALL move to DONE.
REQ-018 DONE: valid SHALL be 1 and busy 0 for the same cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-019 valid, period and overflow SHALL hold until the next start is accepted.
REQ-020 start SHALL be ignored in ARM, MEASURE and DONE.
REQ-021 If start and edge_p coincide in IDLE, start SHALL be accepted and that edge_p ignored; the next edge_p is the first edge.
REQ-022 If edge_p occurs in the same cycle the counter saturates, the edge SHALL take priority and overflow SHALL stay 0.
REQ-023 An edge_p occurring in IDLE or DONE SHALL have no effect.

Reset
REQ-024 When reset=0, the FSM SHALL go to IDLE, and period, counter, valid, busy, overflow, the synchronizer flops and the edge-detector flop SHALL all go to 0.
REQ-025 reset asserted mid-measurement SHALL abort the measurement with no valid pulse.
REQ-026 After reset deasserts, the first edge_p SHALL NOT be generated from a stale synchronizer value.

Configuration
REQ-027 With TICK_PERIOD_METER_AVG_EN defined, a measurement SHALL span 4 consecutive periods, accumulate into a CNT_WIDTH+2 bit sum, and report period = sum >> 2 (truncated).
REQ-028 With TICK_PERIOD_METER_AVG_EN defined, overflow SHALL set if the sum saturates.
REQ-029 With TICK_PERIOD_METER_AVG_EN undefined, a single period SHALL be measured as in REQ-014 to REQ-017, and no accumulator logic SHALL exist.

Structure
REQ-030 The state encoding (IDLE=0, ARM=1, MEASURE=2, DONE=3) and the averaging count (4) SHALL live in shared package tick_period_meter_pkg.
REQ-031 The synchronizer and edge detector SHALL be sub-module tick_edge_sync (parameter SYNC_STAGES; ports clk, reset, d, rise).

Verification
REQ-032 Bench: tick_in from a divide-by-12 frequency divider, start pulsed once -> valid=1 with period=12 and overflow=0.
REQ-033 Bench: CNT_WIDTH=4, tick period 40 clks -> period=15, overflow=1, valid=1.
REQ-034 Bench: start repulsed in MEASURE -> ignored; result equals the uninterrupted period.
REQ-035 Bench: start coincident with edge_p in IDLE -> edge ignored; period is measured from the next two edges.
REQ-036 Bench: reset=0 in MEASURE -> all outputs 0 immediately; a later start measures normally.
REQ-037 Bench, with TICK_PERIOD_METER_AVG_EN: periods 10, 11, 12, 13 -> period=11 (46>>2).

Source files
------------

// File: rtl/tick_period_meter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tick_period_meter_pkg
// Purpose  : Shared FSM state encoding and averaging constants for the
//            tick period meter.
// Revision : 1.0
// ============================================================================
package tick_period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int unsigned AVG_PERIODS = 4;
    localparam int unsigned AVG_SHIFT   = $clog2(AVG_PERIODS);

endpackage
`default_nettype wire

// File: rtl/tick_edge_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tick_edge_sync
// Purpose  : Multi-flop synchronizer followed by a rising-edge detector.
//            SYNC_STAGES must be at least 2.
// Revision : 1.0
// ============================================================================
module tick_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   fill_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges are suppressed until the whole chain holds samples taken after
    // reset release, so a level already high at release is not a rise.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q & fill_q[SYNC_STAGES];

endmodule
`default_nettype wire

// File: rtl/tick_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tick_period_meter
// Purpose  : Measures clk cycles between rising edges of an asynchronous
//            tick. Define TICK_PERIOD_METER_AVG_EN to average 4 periods.
// Revision : 1.0
// ============================================================================
module tick_period_meter
    import tick_period_meter_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 tick_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 valid,
    output logic                 busy,
    output logic                 overflow
);

`ifdef TICK_PERIOD_METER_AVG_EN
    localparam int ACC_W = CNT_WIDTH + 2;
`else
    localparam int ACC_W = CNT_WIDTH;
`endif

    localparam logic [ACC_W-1:0] c_cnt_max = '1;
    localparam logic [ACC_W-1:0] c_cnt_one = ACC_W'(1);

    state_e                 state_q, state_d;
    logic [ACC_W-1:0]       cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;
    logic                   w_edge_p;

`ifdef TICK_PERIOD_METER_AVG_EN
    localparam logic [AVG_SHIFT-1:0] c_last_edge = AVG_SHIFT'(AVG_PERIODS - 1);
    logic [AVG_SHIFT-1:0]   nedge_q, nedge_d;
`endif

    tick_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (tick_in),
        .rise  (w_edge_p)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef TICK_PERIOD_METER_AVG_EN
            nedge_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
`ifdef TICK_PERIOD_METER_AVG_EN
            nedge_q  <= nedge_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
`ifdef TICK_PERIOD_METER_AVG_EN
        nedge_d  = nedge_q;
`endif
        case (state_q)
            IDLE: begin
                // A coincident edge is deliberately dropped here.
                if (start) begin
                    state_d = ARM;
                    valid_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ARM: begin
                if (w_edge_p) begin
                    cnt_d   = c_cnt_one;
                    state_d = MEASURE;
`ifdef TICK_PERIOD_METER_AVG_EN
                    nedge_d = '0;
`endif
                end
            end
            MEASURE: begin
`ifdef TICK_PERIOD_METER_AVG_EN
                // The counter runs across all periods, so it is the sum.
                if (w_edge_p && (nedge_q == c_last_edge)) begin
                    period_d = CNT_WIDTH'(cnt_q >> AVG_SHIFT);
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else if (cnt_q == c_cnt_max) begin
                    period_d = '1;
                    ovf_d    = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                    if (w_edge_p) begin
                        nedge_d = nedge_q + 1'b1;
                    end
                end
`else
                if (w_edge_p) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else if (cnt_q == c_cnt_max) begin
                    period_d = '1;
                    ovf_d    = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign period   = period_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == ARM) || (state_q == MEASURE);

endmodule
`default_nettype wire

// File: tb/tb_tick_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tick_period_meter
// Purpose  : Randomized scoreboard bench for tick_period_meter, two widths.
// Revision : 1.0
// ============================================================================
module tb_tick_period_meter;

    localparam int S     = 2;
    localparam int WA    = 16;
    localparam int WB    = 4;
    localparam int AVG_N = 4;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          start   = 1'b0;
    logic          tick_in = 1'b0;
    logic [WA-1:0] per_a;
    logic [WB-1:0] per_b;
    logic          va, vb, ba, bb, oa, ob;

    always #5 clk = ~clk;

    tick_period_meter #(.CNT_WIDTH(WA), .SYNC_STAGES(S)) dut_a (
        .clk(clk), .reset(reset), .start(start), .tick_in(tick_in),
        .period(per_a), .valid(va), .busy(ba), .overflow(oa)
    );

    tick_period_meter #(.CNT_WIDTH(WB), .SYNC_STAGES(S)) dut_b (
        .clk(clk), .reset(reset), .start(start), .tick_in(tick_in),
        .period(per_b), .valid(vb), .busy(bb), .overflow(ob)
    );

    typedef struct {
        int per;
        int ov;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   hi    = 0;
    int   rise_q[$];
    int   pl[$];
    bit   pa    = 1'b0;
    bit   pb    = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Reference: a measurement covers the tick rises whose edges arrive
    // after the start cycle; result is the span of 1 (or 4) periods.
    function automatic exp_t model(input int j, input int rises[$], input int w);
        int     r[$];
        exp_t   e;
        longint tot;
        longint mx;
        foreach (rises[i]) if (rises[i] > j - S) r.push_back(rises[i]);
`ifdef TICK_PERIOD_METER_AVG_EN
        tot = longint'(r[AVG_N] - r[0]);
        mx  = (64'd1 << (w + 2)) - 1;
        if (tot > mx) begin
            e.per = int'((64'd1 << w) - 1);
            e.ov  = 1;
        end else begin
            e.per = int'(tot / AVG_N);
            e.ov  = 0;
        end
`else
        tot = longint'(r[1] - r[0]);
        mx  = (64'd1 << w) - 1;
        if (tot > mx) begin
            e.per = int'(mx);
            e.ov  = 1;
        end else begin
            e.per = int'(tot);
            e.ov  = 0;
        end
`endif
        return e;
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        if (rise_q.size() > 0 && rise_q[0] == cyc) begin
            void'(rise_q.pop_front());
            hi = 2;
        end
        tick_in = (hi > 0);
        if (hi > 0) hi--;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (va && !pa) begin
                if (qa.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_valid_a: got valid=1 expected no result");
                end else begin
                    e = qa.pop_front();
                    chk("period_a", int'(per_a), e.per);
                    chk("overflow_a", int'(oa), e.ov);
                    chk("busy_at_done_a", int'(ba), 0);
                end
            end
            pa = va;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (vb && !pb) begin
                if (qb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_valid_b: got valid=1 expected no result");
                end else begin
                    e = qb.pop_front();
                    chk("period_b", int'(per_b), e.per);
                    chk("overflow_b", int'(ob), e.ov);
                    chk("busy_at_done_b", int'(bb), 0);
                end
            end
            pb = vb;
        end
    end

    task automatic run_case(input bit coinc, input bit rep);
        int j, k0, k1, rep_t, r;
        int rises[$];
        bit done;
        repeat (4) step();
        if (coinc) begin
            k0 = cyc + 1;
            j  = k0 + S;
        end else begin
            j  = cyc + 1;
            k0 = j + 2;
        end
        r = k0;
        rises.push_back(r);
        for (int i = 0; i < 6; i++) begin
            r += pl[(i < pl.size()) ? i : pl.size() - 1];
            rises.push_back(r);
        end
        rise_q = rises;
        qa.push_back(model(j, rises, WA));
        qb.push_back(model(j, rises, WB));
        k1 = 0;
        foreach (rises[i]) if (k1 == 0 && rises[i] > j - S) k1 = rises[i];
        rep_t = k1 + S + 2;
        done  = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            step();
            start = (cyc == j) || (rep && cyc == rep_t);
            if (cyc == rep_t) begin
                chk("busy_measure_a", int'(ba), 1);
                chk("busy_measure_b", int'(bb), 1);
            end
            if (cyc > j && qa.size() == 0 && qb.size() == 0) done = 1'b1;
        end
        start = 1'b0;
        if (!done) begin
            tests++; fails++;
            $display("FAIL timeout: got %0d pending results expected 0", qa.size() + qb.size());
            qa.delete();
            qb.delete();
        end
        while (rise_q.size() > 0 || hi > 0) step();
        if (done) begin
            chk("valid_hold_a", int'(va), 1);
            chk("valid_hold_b", int'(vb), 1);
        end
    endtask

    initial begin
        int j, k0;
        reset = 1'b0;
        repeat (3) step();
        #1;
        chk("rst_period_a", int'(per_a), 0);
        chk("rst_valid_a", int'(va), 0);
        chk("rst_busy_a", int'(ba), 0);
        chk("rst_overflow_a", int'(oa), 0);
        chk("rst_period_b", int'(per_b), 0);
        chk("rst_valid_b", int'(vb), 0);
        chk("rst_busy_b", int'(bb), 0);
        chk("rst_overflow_b", int'(ob), 0);
        reset = 1'b1;
        repeat (S + 3) step();

        pl = {12};              run_case(1'b0, 1'b0);
        pl = {40};              run_case(1'b0, 1'b0);
        pl = {15};              run_case(1'b0, 1'b0);
        pl = {16};              run_case(1'b0, 1'b0);
        pl = {20};              run_case(1'b0, 1'b1);
        pl = {9, 14};           run_case(1'b1, 1'b0);

        // Abort mid-measurement with reset.
        repeat (4) step();
        j  = cyc + 1;
        k0 = j + 2;
        rise_q = {k0, k0 + 25, k0 + 50};
        while (cyc < k0 + S + 4) begin
            step();
            start = (cyc == j);
        end
        start = 1'b0;
        chk("busy_before_abort_a", int'(ba), 1);
        reset = 1'b0;
        #1;
        chk("abort_period_a", int'(per_a), 0);
        chk("abort_valid_a", int'(va), 0);
        chk("abort_busy_a", int'(ba), 0);
        chk("abort_overflow_a", int'(oa), 0);
        chk("abort_period_b", int'(per_b), 0);
        chk("abort_busy_b", int'(bb), 0);
        rise_q.delete();
        hi = 0;
        tick_in = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (S + 4) step();

        pl = {17};              run_case(1'b0, 1'b0);
        pl = {10, 11, 12, 13};  run_case(1'b0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            pl.delete();
            for (int i = 0; i < 6; i++) pl.push_back(int'($urandom_range(5, 30)));
            run_case(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (5) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
